mac_reduce_tree: RTL and testbench
==================================

# mac_reduce_tree

Parametrised, pipelined reduction-and-accumulate unit for the mixed-precision MAC datapath. It takes NUM_LANES signed partial products per beat and sums them through a registered adder tree. It then accumulates the per-beat sums across a multi-beat group delimited by a last flag, and presents one result per group on a valid/ready output. It replaces the fixed 4-lane, two-clock pairwise adder with a single-clock design that supports any lane count, backpressure, an optional saturating accumulator, and the packed dual-16-bit mode.

## Interface
Parameters:
- NUM_LANES, 8, product lanes per beat; power of two, 2..32; L = log2(NUM_LANES) tree stages.
- ACC_W, 32, product and result width; even.
- SAT, 0, accumulator overflow behaviour; 1 = signed saturate per segment, 0 = two's-complement wrap.

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  beat present.
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o.
- in_last_i  in  1  final beat of current group.
- mode_i  in  2  3 = split: two independent signed ACC_W/2 segments; 0..2 = one signed ACC_W value.
- prods_i  in  NUM_LANES x ACC_W  signed partial products (packed per mode).
- sum_valid_o  out  1  group result available.
- sum_ready_i  in  1  consumer accepts result.
- sum_o  out  ACC_W  group result (packed per mode).
- busy_o  out  1  any beat in flight, group open, or result pending.

## Operation
- Tree: L registered stages. Each stage adds adjacent pairs.
- Internal width per segment is segment width + L, so the tree never overflows.
- In split mode, segments are sign-extended independently. No carry crosses the segment boundary at any stage.
- Each stage carries valid, last and mode alongside its data.
- Mode is sampled on the first beat of a group and held for the whole group. Changes to mode_i mid-group are ignored.
- Accumulator, on each tree-output beat:
  - acc = (group_first ? 0 : acc) + tree_sum, per segment.
  - SAT=1: clamp each segment to [-2^(w-1), 2^(w-1)-1], where w = ACC_W or ACC_W/2.
  - SAT=0: truncate to w bits.
- On a tree-output beat with last set: load acc result into the output register, assert sum_valid_o, and mark the next beat as group_first.
- Stall: stall = sum_valid_o & ~sum_ready_i & (tree-output beat has last).
  - While stalled, all pipeline stages and the accumulator hold.
  - in_ready_o = ~stall.
  - Non-last beats drain freely into the accumulator.
- Output: sum_o is stable while sum_valid_o & ~sum_ready_i. sum_valid_o clears on handshake unless a new result loads in the same cycle; in that case it stays high and sum_o updates.
- busy_o = OR of stage valids | group open | sum_valid_o.

## Timing
- Reset (rst_i high at a clock edge):
  - All stage valids, acc, group-open cleared; group_first set.
  - sum_valid_o=0, sum_o=0, busy_o=0, in_ready_o=1 from the next cycle.
  - Reset mid-group discards all in-flight beats and partial sums. No result is produced for that group.
- Latency: last beat accepted at cycle 0 gives sum_valid_o high at cycle L+1 (NUM_LANES=8: cycle 4), absent stall.
- Throughput: one beat per cycle. Back-to-back single-beat groups give one result per cycle when sum_ready_i=1.
- A simultaneous output handshake and new last beat arriving at the accumulator causes no stall and no bubble.
- in_ready_o is combinational from sum_valid_o, sum_ready_i and the last flag of the final tree stage. It does not depend on in_valid_i.
- A beat with in_valid_i=0 inserts a bubble. The accumulator holds across bubbles.

## Test plan
- Single beat, NUM_LANES=8, mode 0, prods 1..8, last=1 -> sum_o=36 (0x24), sum_valid_o at cycle 4.
- Three-beat group of all lanes = -1, mode 0 -> sum_o=0xFFFFFFE8 (-24). A following single beat of all 2 -> next sum_o=16; no leakage across groups.
- Mode 3, every lane 0x0001_FFFF (upper +1, lower -1) -> sum_o=0x0008_FFF8; no cross-segment carry. A mode_i change on the second beat of the group has no effect.
- SAT=1, mode 0, two beats each lane 0x1000_0000 -> sum_o=0x7FFF_FFFF. With SAT=0 -> sum_o wraps to 0x0000_0000.
- Hold sum_ready_i=0 for 10 cycles with 3 more groups streaming -> sum_o stable; in_ready_o drops only when a last beat reaches the accumulator. Results emerge in order, with none lost or duplicated, after release.
- Assert rst_i for one cycle mid-group with two beats in the tree -> next cycle sum_valid_o=0, busy_o=0. The next full group sums correctly from zero.

Source files
------------

// File: rtl/mac_reduce_tree.sv
`default_nettype none
// ============================================================================
// mac_reduce_tree - pipelined signed adder tree with grouped accumulate,
// optional per-segment saturation and packed dual-half mode. Revision: 1.0
// ============================================================================
module mac_reduce_tree #(
  parameter int NUM_LANES = 8,
  parameter int ACC_W     = 32,
  parameter bit SAT       = 1'b0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic                            in_last_i,
  input  logic [1:0]                      mode_i,
  input  logic [NUM_LANES-1:0][ACC_W-1:0] prods_i,
  output logic                            sum_valid_o,
  input  logic                            sum_ready_i,
  output logic [ACC_W-1:0]                sum_o,
  output logic                            busy_o
);
  localparam int C_L   = $clog2(NUM_LANES);
  localparam int C_HW  = ACC_W / 2;
  localparam int C_FW  = ACC_W + C_L;
  localparam int C_SW  = C_HW + C_L;
  localparam int C_AFW = C_FW + 1;
  localparam int C_ASW = C_SW + 1;
  localparam int C_NH  = NUM_LANES / 2;
  localparam logic [1:0]       C_MODE_SPLIT = 2'd3;
  localparam logic [ACC_W-1:0] C_MAX_F = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_MIN_F = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [C_HW-1:0]  C_MAX_H = {1'b0, {(C_HW-1){1'b1}}};
  localparam logic [C_HW-1:0]  C_MIN_H = {1'b1, {(C_HW-1){1'b0}}};

  logic [C_L:1]           r_vld;
  logic [C_L:1]           r_last;
  logic [1:0]             r_mode [1:C_L];
  logic signed [C_FW-1:0] r_full [1:C_L][C_NH];
  logic signed [C_SW-1:0] r_hi   [1:C_L][C_NH];
  logic signed [C_SW-1:0] r_lo   [1:C_L][C_NH];

  logic                   r_in_open;
  logic [1:0]             r_grp_mode;
  logic [ACC_W-1:0]       r_acc;
  logic                   r_first;
  logic [ACC_W-1:0]       r_sum;
  logic                   r_sum_vld;

  logic                   w_stall;
  logic                   w_accept;
  logic                   w_acc_beat;
  logic [1:0]             w_beat_mode;

  // Only a result-bearing beat waiting on a full output register blocks the pipe.
  assign w_stall     = r_sum_vld & ~sum_ready_i & r_vld[C_L] & r_last[C_L];
  assign in_ready_o  = ~w_stall;
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_acc_beat  = r_vld[C_L] & ~w_stall;
  assign w_beat_mode = r_in_open ? r_grp_mode : mode_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_in_open <= 1'b0;
    end else if (w_accept) begin
      r_in_open <= ~in_last_i;
      if (!r_in_open) r_grp_mode <= mode_i;
    end
  end

  for (genvar s = 1; s <= C_L; s++) begin : g_stage
    localparam int C_N = NUM_LANES >> s;
    logic signed [C_FW-1:0] w_in_full [2*C_N];
    logic signed [C_SW-1:0] w_in_hi   [2*C_N];
    logic signed [C_SW-1:0] w_in_lo   [2*C_N];
    logic                   w_in_vld;
    logic                   w_in_last;
    logic [1:0]             w_in_mode;

    if (s == 1) begin : g_src_in
      // Each half is sign-extended on its own so split mode never carries across.
      always_comb begin
        w_in_vld  = w_accept;
        w_in_last = in_last_i;
        w_in_mode = w_beat_mode;
        for (int i = 0; i < 2*C_N; i++) begin
          w_in_full[i] = C_FW'($signed(prods_i[i]));
          w_in_hi[i]   = C_SW'($signed(prods_i[i][ACC_W-1:C_HW]));
          w_in_lo[i]   = C_SW'($signed(prods_i[i][C_HW-1:0]));
        end
      end
    end else begin : g_src_prev
      always_comb begin
        w_in_vld  = r_vld[s-1];
        w_in_last = r_last[s-1];
        w_in_mode = r_mode[s-1];
        for (int i = 0; i < 2*C_N; i++) begin
          w_in_full[i] = r_full[s-1][i];
          w_in_hi[i]   = r_hi[s-1][i];
          w_in_lo[i]   = r_lo[s-1][i];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_vld[s] <= 1'b0;
      end else if (!w_stall) begin
        r_vld[s]  <= w_in_vld;
        r_last[s] <= w_in_last;
        r_mode[s] <= w_in_mode;
        for (int i = 0; i < C_N; i++) begin
          r_full[s][i] <= w_in_full[2*i] + w_in_full[2*i+1];
          r_hi[s][i]   <= w_in_hi[2*i]   + w_in_hi[2*i+1];
          r_lo[s][i]   <= w_in_lo[2*i]   + w_in_lo[2*i+1];
        end
      end
    end
  end

  logic signed [C_AFW-1:0] w_sum_full;
  logic signed [C_ASW-1:0] w_sum_hi;
  logic signed [C_ASW-1:0] w_sum_lo;
  logic [ACC_W-1:0]        w_base;
  logic [ACC_W-1:0]        w_res_full;
  logic [C_HW-1:0]         w_res_hi;
  logic [C_HW-1:0]         w_res_lo;
  logic [ACC_W-1:0]        w_acc_next;

  always_comb begin
    w_base     = r_first ? '0 : r_acc;
    w_sum_full = C_AFW'($signed(w_base)) + C_AFW'(r_full[C_L][0]);
    w_sum_hi   = C_ASW'($signed(w_base[ACC_W-1:C_HW])) + C_ASW'(r_hi[C_L][0]);
    w_sum_lo   = C_ASW'($signed(w_base[C_HW-1:0])) + C_ASW'(r_lo[C_L][0]);
    w_res_full = w_sum_full[ACC_W-1:0];
    w_res_hi   = w_sum_hi[C_HW-1:0];
    w_res_lo   = w_sum_lo[C_HW-1:0];
    // A value fits in w bits exactly when every bit above bit w-2 matches the sign.
    if (SAT) begin
      if (!((&w_sum_full[C_AFW-1:ACC_W-1]) || !(|w_sum_full[C_AFW-1:ACC_W-1])))
        w_res_full = w_sum_full[C_AFW-1] ? C_MIN_F : C_MAX_F;
      if (!((&w_sum_hi[C_ASW-1:C_HW-1]) || !(|w_sum_hi[C_ASW-1:C_HW-1])))
        w_res_hi = w_sum_hi[C_ASW-1] ? C_MIN_H : C_MAX_H;
      if (!((&w_sum_lo[C_ASW-1:C_HW-1]) || !(|w_sum_lo[C_ASW-1:C_HW-1])))
        w_res_lo = w_sum_lo[C_ASW-1] ? C_MIN_H : C_MAX_H;
    end
    w_acc_next = (r_mode[C_L] == C_MODE_SPLIT) ? {w_res_hi, w_res_lo} : w_res_full;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc     <= '0;
      r_first   <= 1'b1;
      r_sum     <= '0;
      r_sum_vld <= 1'b0;
    end else begin
      if (w_acc_beat) begin
        r_acc   <= w_acc_next;
        r_first <= r_last[C_L];
      end
      if (w_acc_beat && r_last[C_L]) begin
        r_sum     <= w_acc_next;
        r_sum_vld <= 1'b1;
      end else if (sum_ready_i) begin
        r_sum_vld <= 1'b0;
      end
    end
  end

  assign sum_valid_o = r_sum_vld;
  assign sum_o       = r_sum;
  assign busy_o      = (|r_vld) | r_in_open | r_sum_vld;

endmodule
`default_nettype wire

// File: tb/tb_mac_reduce_tree.sv
`default_nettype none
// ============================================================================
// tb_mac_reduce_tree - directed bench for mac_reduce_tree (wrap and saturate
// instances side by side) with an arithmetic group model. Revision: 1.0
// ============================================================================
module tb_mac_reduce_tree;
  localparam int NL     = 8;
  localparam int AW     = 32;
  localparam int HW     = AW / 2;
  localparam int BUDGET = 60;

  typedef logic [AW-1:0]          word_t;
  typedef logic [NL-1:0][AW-1:0]  lanes_t;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               in_valid_i;
  logic               in_last_i;
  logic               sum_ready_i;
  logic [1:0]         mode_i;
  lanes_t             prods_i;
  logic [1:0]         in_ready;
  logic [1:0]         sum_valid;
  logic [1:0]         busy;
  logic [1:0][AW-1:0] sum_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_reduce_tree #(.NUM_LANES(NL), .ACC_W(AW), .SAT(1'b0)) u_dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready[0]),
    .in_last_i(in_last_i), .mode_i(mode_i), .prods_i(prods_i),
    .sum_valid_o(sum_valid[0]), .sum_ready_i(sum_ready_i), .sum_o(sum_v[0]),
    .busy_o(busy[0])
  );

  mac_reduce_tree #(.NUM_LANES(NL), .ACC_W(AW), .SAT(1'b1)) u_dut_sat (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready[1]),
    .in_last_i(in_last_i), .mode_i(mode_i), .prods_i(prods_i),
    .sum_valid_o(sum_valid[1]), .sum_ready_i(sum_ready_i), .sum_o(sum_v[1]),
    .busy_o(busy[1])
  );

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Group model: plain signed sums per beat, fitted to w bits after every beat.
  word_t      exp_q [2][$];
  longint     m_full [2];
  longint     m_hi [2];
  longint     m_lo [2];
  bit         m_open [2];
  logic [1:0] m_mode [2];
  int         n_hs [2];

  function automatic longint fit(input longint v, input int w, input bit sat);
    longint lim = longint'(1) <<< (w - 1);
    longint m;
    if (sat) begin
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
    end
    m = v & ((lim <<< 1) - 1);
    return (m >= lim) ? m - (lim <<< 1) : m;
  endfunction

  task automatic model_beat(input int k);
    longint     sf = 0;
    longint     sh = 0;
    longint     sl = 0;
    bit         sat = (k == 1);
    logic [1:0] md;
    word_t      r;
    md = m_open[k] ? m_mode[k] : mode_i;
    if (!m_open[k]) begin
      m_full[k] = 0;
      m_hi[k]   = 0;
      m_lo[k]   = 0;
      m_mode[k] = mode_i;
    end
    for (int i = 0; i < NL; i++) begin
      sf += longint'($signed(prods_i[i]));
      sh += longint'($signed(prods_i[i][AW-1:HW]));
      sl += longint'($signed(prods_i[i][HW-1:0]));
    end
    m_full[k] = fit(m_full[k] + sf, AW, sat);
    m_hi[k]   = fit(m_hi[k] + sh, HW, sat);
    m_lo[k]   = fit(m_lo[k] + sl, HW, sat);
    if (in_last_i) begin
      r = (md == 2'd3) ? {m_hi[k][HW-1:0], m_lo[k][HW-1:0]} : m_full[k][AW-1:0];
      exp_q[k].push_back(r);
      m_open[k] = 1'b0;
    end else begin
      m_open[k] = 1'b1;
    end
  endtask

  // Inputs change at posedge+2, so the falling edge sees exactly what the next rising edge will.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_i) begin
        exp_q[k].delete();
        m_open[k] = 1'b0;
      end else begin
        if (sum_valid[k]) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_result dut%0d: got sum_valid=1 sum_o=0x%0h, required no result", k, sum_v[k]);
          end else begin
            check($sformatf("stream_sum dut%0d", k), sum_v[k], exp_q[k][0]);
            if (sum_ready_i) begin
              void'(exp_q[k].pop_front());
              n_hs[k]++;
            end
          end
        end
        if (in_valid_i && in_ready[k]) model_beat(k);
      end
    end
  end

  function automatic lanes_t fill(input word_t v);
    lanes_t p;
    for (int i = 0; i < NL; i++) p[i] = v;
    return p;
  endfunction

  task automatic send(input logic [1:0] md, input logic last, input lanes_t p, output int waited);
    in_valid_i = 1'b1;
    in_last_i  = last;
    mode_i     = md;
    prods_i    = p;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (in_ready[0]) break;
      waited++;
      if (waited > BUDGET) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", waited);
        break;
      end
    end
    @(posedge clk); #2;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic expect_result(input string name, input word_t e_wrap, input word_t e_sat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sum_valid[0] && n < BUDGET);
    check({name, "_valid"}, 32'(sum_valid[0] & sum_valid[1]), 32'd1);
    check({name, "_wrap"}, sum_v[0], e_wrap);
    check({name, "_sat"}, sum_v[1], e_sat);
    @(posedge clk); #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy != 2'b00 || exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < BUDGET), 32'd1);
    @(posedge clk); #2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int     w;
    int     wsum;
    int     lat;
    int     run;
    int     hs0;
    lanes_t p;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    mode_i      = 2'd0;
    prods_i     = '0;
    sum_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_i = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_sum_valid dut%0d", k), 32'(sum_valid[k]), 32'd0);
      check($sformatf("reset_busy dut%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("reset_in_ready dut%0d", k), 32'(in_ready[k]), 32'd1);
      check($sformatf("reset_sum_o dut%0d", k), sum_v[k], 32'd0);
    end
    @(posedge clk); #2;

    // Ramp 1..8 in one beat: latency and plain sum.
    for (int i = 0; i < NL; i++) p[i] = word_t'(i + 1);
    send(2'd0, 1'b1, p, w);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_in_flight", 32'(busy[0]), 32'd1);
      if (sum_valid[0]) lat = c;
    end
    check("latency_cycles", 32'(lat), 32'd4);
    check("ramp_sum_wrap", sum_v[0], 32'd36);
    check("ramp_sum_sat", sum_v[1], 32'd36);
    @(posedge clk); #2;

    // Three beats of -1 with a bubble, then a fresh single-beat group.
    send(2'd0, 1'b0, fill(32'hFFFF_FFFF), w);
    send(2'd0, 1'b0, fill(32'hFFFF_FFFF), w);
    repeat (3) begin @(posedge clk); #2; end
    send(2'd0, 1'b1, fill(32'hFFFF_FFFF), w);
    send(2'd0, 1'b1, fill(32'd2), w);
    expect_result("neg_group", 32'hFFFF_FFE8, 32'hFFFF_FFE8);
    expect_result("after_neg", 32'd16, 32'd16);

    // Split mode: halves independent, mode change mid-group ignored.
    send(2'd3, 1'b1, fill(32'h0001_FFFF), w);
    expect_result("split_single", 32'h0008_FFF8, 32'h0008_FFF8);
    send(2'd3, 1'b0, fill(32'h0001_FFFF), w);
    send(2'd0, 1'b1, fill(32'h0000_0001), w);
    expect_result("split_mode_hold", 32'h0008_0000, 32'h0008_0000);

    // Overflow: wrap instance vs saturating instance.
    send(2'd0, 1'b0, fill(32'h1000_0000), w);
    send(2'd0, 1'b1, fill(32'h1000_0000), w);
    expect_result("ovf_pos_full", 32'h0000_0000, 32'h7FFF_FFFF);
    send(2'd0, 1'b1, fill(32'hC000_0001), w);
    expect_result("ovf_neg_full", 32'h0000_0008, 32'h8000_0000);
    send(2'd3, 1'b1, fill(32'h4000_C000), w);
    expect_result("ovf_split", 32'h0000_0000, 32'h7FFF_8000);

    // Back-to-back single-beat groups: one beat and one result per cycle.
    wsum = 0;
    for (int g = 1; g <= 4; g++) begin
      send(2'd0, 1'b1, fill(word_t'(g)), w);
      wsum += w;
    end
    check("b2b_accept_waits", 32'(wsum), 32'd0);
    run = 0;
    for (int c = 0; c < BUDGET && run == 0; c++) begin
      @(negedge clk);
      if (sum_valid[0]) run = 1;
    end
    check("b2b_first", sum_v[0], 32'd8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (sum_valid[0]) run++;
    end
    check("b2b_run_length", 32'(run), 32'd4);
    @(posedge clk); #2;
    drain("b2b_drain");

    // Backpressure: output held for 10 cycles while three more groups stream in.
    hs0 = n_hs[0];
    sum_ready_i = 1'b0;
    fork
      begin
        int ws;
        send(2'd0, 1'b1, fill(32'd1), ws);
        send(2'd0, 1'b0, fill(32'd2), ws);
        send(2'd0, 1'b1, fill(32'd2), ws);
        send(2'd0, 1'b0, fill(32'd3), ws);
        send(2'd0, 1'b1, fill(32'd3), ws);
        send(2'd0, 1'b0, fill(32'd4), ws);
        send(2'd0, 1'b1, fill(32'd4), ws);
      end
      begin
        int acc_n;
        int low;
        acc_n = 0;
        low   = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (in_valid_i && in_ready[0]) acc_n++;
          if (!in_ready[0]) low = 1;
        end
        check("stall_beats_taken", 32'(acc_n), 32'd5);
        check("stall_in_ready_dropped", 32'(low), 32'd1);
        check("stall_valid_held", 32'(sum_valid[0]), 32'd1);
        check("stall_sum_held", sum_v[0], 32'd8);
        @(posedge clk); #2;
        sum_ready_i = 1'b1;
      end
    join
    drain("stall_drain");
    check("stall_results_count", 32'(n_hs[0] - hs0), 32'd4);

    // Reset mid-group with two beats inside the tree.
    send(2'd0, 1'b0, fill(32'd5), w);
    send(2'd0, 1'b0, fill(32'd6), w);
    rst_i = 1'b1;
    @(posedge clk); #2;
    rst_i = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midreset_sum_valid dut%0d", k), 32'(sum_valid[k]), 32'd0);
      check($sformatf("midreset_busy dut%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("midreset_in_ready dut%0d", k), 32'(in_ready[k]), 32'd1);
    end
    @(posedge clk); #2;
    send(2'd0, 1'b0, fill(32'd7), w);
    send(2'd0, 1'b1, fill(32'd1), w);
    expect_result("post_reset", 32'd64, 32'd64);

    drain("final_drain");
    check("final_queue_wrap", 32'(exp_q[0].size()), 32'd0);
    check("final_queue_sat", 32'(exp_q[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
